// File: rtl/prog_loader_ram_if.sv
// Bus bundle between the UART-side loader RAM and its user: mode/step/address
// controls and the incoming byte in one direction, read word and status back.
interface prog_loader_ram_if #(
  parameter int BYTE_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_WIDTH     = 8
);
  logic [1:0]                           MODE;
  logic                                 DEBUG;
  logic [ADDR_WIDTH-1:0]                address;
  logic [BYTE_WIDTH-1:0]                data_in;
  logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] data_out;
  logic [ADDR_WIDTH:0]                  word_count;
  logic                                 full;
  logic                                 overflow;
  logic                                 frame_err;

  modport master (
    output MODE, DEBUG, address, data_in,
    input  data_out, word_count, full, overflow, frame_err
  );

  modport slave (
    input  MODE, DEBUG, address, data_in,
    output data_out, word_count, full, overflow, frame_err
  );
endinterface

// File: rtl/prog_loader_ram.sv
// Packs a held-byte, delimiter-separated UART stream into big-endian words in an
// internal RAM and serves them back by button-stepped debug readout or fetch.
module prog_loader_ram #(
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    BYTES_PER_WORD = 2,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DEPTH          = 256,
  parameter logic [BYTE_WIDTH-1:0] DELIM          = 8'h24,
  parameter logic [BYTE_WIDTH-1:0] IDLE_BYTE      = 8'h00
) (
  input logic              clk,
  input logic              rst,
  prog_loader_ram_if.slave bus
);
  localparam int WORD_W = BYTE_WIDTH * BYTES_PER_WORD;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ARMED, HELD} cap_state_t;

  cap_state_t            st;
  logic [2:0]            byte_idx;
  logic [WORD_W-1:0]     pack;
  logic [BYTE_WIDTH-1:0] last_byte;
  logic [ADDR_WIDTH-1:0] dbg_ptr;
  logic                  debug_q;
  logic [1:0]            mode_q;
  logic [WORD_W-1:0]     mem [DEPTH];

  logic                  is_data;
  logic                  cap;
  logic                  word_done;
  logic                  wr_en;
  logic                  dbg_step;
  logic [WORD_W-1:0]     next_word;
  logic [WORD_W-1:0]     fetch_word;
  logic [CNT_W-1:0]      wc_inc;
  logic [CNT_W-1:0]      ptr_inc;

  // Earlier bytes shift toward the MSBs, so the first byte of a word ends on top.
  function automatic logic [WORD_W-1:0] pack_byte(input logic [WORD_W-1:0]     w,
                                                  input logic [BYTE_WIDTH-1:0] b);
    logic [WORD_W-1:0] s;
    s = w << BYTE_WIDTH;
    s[BYTE_WIDTH-1:0] = b;
    return s;
  endfunction

  assign is_data    = (bus.data_in != IDLE_BYTE) && (bus.data_in != DELIM);
  assign cap        = (bus.MODE == 2'd0) && is_data &&
                      ((st == ARMED) || (bus.data_in != last_byte));
  assign word_done  = cap && (byte_idx == 3'(BYTES_PER_WORD - 1));
  assign next_word  = pack_byte(pack, bus.data_in);
  assign wr_en      = rst && word_done && !bus.full;
  assign wc_inc     = bus.word_count + CNT_W'(1);
  assign ptr_inc    = {1'b0, dbg_ptr} + CNT_W'(1);
  // A step needs a fresh DEBUG edge, not the first debug cycle, and room below word_count.
  assign dbg_step   = bus.DEBUG && !debug_q && (mode_q == 2'd1) && (ptr_inc < bus.word_count);
  assign fetch_word = ({1'b0, bus.address} < bus.word_count) ? mem[bus.address[IDX_W-1:0]] : '0;

  // Byte datapath and RAM: no reset, stale bits are flushed by the next full word.
  always_ff @(posedge clk) begin
    if (cap) begin
      last_byte <= bus.data_in;
      pack      <= word_done ? '0 : next_word;
    end
    if (wr_en) mem[bus.word_count[IDX_W-1:0]] <= next_word;
  end

  // Capture FSM, counters, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st             <= ARMED;
      byte_idx       <= '0;
      dbg_ptr        <= '0;
      debug_q        <= 1'b0;
      mode_q         <= 2'd0;
      bus.data_out   <= '0;
      bus.word_count <= '0;
      bus.full       <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      debug_q <= bus.DEBUG;
      mode_q  <= bus.MODE;
      if (bus.MODE != 2'd0) begin
        st       <= ARMED;
        byte_idx <= '0;
      end
      if (bus.MODE != 2'd1) dbg_ptr <= '0;

      case (bus.MODE)
        2'd0: begin
          bus.data_out <= '0;
          if (cap) begin
            st <= HELD;
            if (st == HELD) bus.frame_err <= 1'b1;
            if (word_done) begin
              byte_idx <= '0;
              if (bus.full) begin
                bus.overflow <= 1'b1;
              end else begin
                bus.word_count <= wc_inc;
                bus.full       <= (wc_inc == CNT_W'(DEPTH));
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end else if ((st == HELD) && (bus.data_in == DELIM)) begin
            st <= ARMED;
          end
        end
        2'd1: begin
          bus.data_out <= (bus.word_count == '0) ? '0 : mem[dbg_ptr[IDX_W-1:0]];
          if (dbg_step) dbg_ptr <= dbg_ptr + ADDR_WIDTH'(1);
        end
        2'd2: begin
          bus.data_out <= fetch_word;
        end
        default: begin
          bus.data_out   <= '0;
          bus.word_count <= '0;
          bus.full       <= 1'b0;
          bus.overflow   <= 1'b0;
          bus.frame_err  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/prog_loader_ram.md
Name: prog_loader_ram

Overview:
Parametrised successor to the UART-side intermediary RAM. It captures a UART byte stream in which each byte is held for several cycles and followed by a delimiter, and packs the bytes into words of BYTES_PER_WORD bytes. It stores the words in an internal RAM and serves them to the core in two ways: button-stepped debug readout, or random-access fetch. It adds word packing, a clear mode, saturation and overflow detection, and framing-error detection.

Parameters:
BYTE_WIDTH, 8, width of data_in (one UART byte)
BYTES_PER_WORD, 2, bytes packed per stored word (legal range 1..4)
ADDR_WIDTH, 8, word address width
DEPTH, 256, number of words stored (DEPTH <= 2**ADDR_WIDTH)
DELIM, 8'h24, inter-byte delimiter ('$')
IDLE_BYTE, 8'h00, line value meaning "no data"

Ports:
clk  in  1  system clock, 50 MHz, rising-edge
rst  in  1  asynchronous reset, active-low
MODE  in  2  0 = write, 1 = debug, 2 = fetch, 3 = clear
DEBUG  in  1  step button, already debounced and synchronous
address  in  ADDR_WIDTH  word address for fetch mode
data_in  in  BYTE_WIDTH  byte from the UART receiver, held for multiple cycles
data_out  out  BYTE_WIDTH*BYTES_PER_WORD  registered read word
word_count  out  ADDR_WIDTH+1  number of complete words stored
full  out  1  high when word_count == DEPTH
overflow  out  1  sticky; set when a word completes while full
frame_err  out  1  sticky; set when a new data byte arrives without a delimiter

Behaviour:
- Reset (rst=0, asynchronous): data_out=0, word_count=0, full=0, overflow=0, frame_err=0, packer state ARMED, byte index=0, dbg_ptr=0, DEBUG edge register=0. RAM contents are undefined and not cleared.
- All outputs are registered. data_out updates one clk after its source changes (latency 1).
- Write mode (MODE=0): data_out=0. Capture FSM:
  - ARMED: if data_in is neither IDLE_BYTE nor DELIM, capture the byte into the packer, latch it as last_byte, and go to HELD. DELIM or IDLE_BYTE: stay in ARMED.
  - HELD: data_in == last_byte: stay (one capture per occurrence, however long the byte is held). data_in == DELIM: go to ARMED. data_in == IDLE_BYTE: stay. Any other byte: set frame_err, capture it as a new byte, stay in HELD.
  - Packing is big-endian: the first byte goes to the MSBs. When the byte index reaches BYTES_PER_WORD, the word is written at address word_count in the same cycle as the last capture, and word_count increments on the next edge.
  - If full is set, the word is dropped, overflow is set, and word_count does not change.
- Leaving MODE 0 with a partial word discards the partial bytes and returns the packer to ARMED.
- Debug mode (MODE=1): data_out = mem[dbg_ptr].
  - dbg_ptr is cleared to 0 on every cycle where MODE != 1. On entry it therefore reads word 0 one cycle later.
  - A rising edge of DEBUG (DEBUG=1 with the previous sample 0) increments dbg_ptr. dbg_ptr saturates at word_count-1.
  - A DEBUG held high counts as one step.
  - A DEBUG edge in the first cycle of MODE=1 is ignored.
  - If word_count=0, data_out=0.
- Fetch mode (MODE=2): data_out = mem[address] if address < word_count, else 0. One-cycle registered latency.
- Clear mode (MODE=3): on each cycle, word_count, overflow and frame_err go to 0, the packer returns to ARMED, and data_out=0. RAM contents are untouched but unreachable because word_count=0.
- A MODE change takes effect on the next edge. No write occurs on the cycle MODE leaves 0.
- Reset mid-stream aborts the partial word and word_count returns to 0.

Test Plan:
- Reset: rst=0 for 1 cycle -> data_out=0, word_count=0, full=0, overflow=0, frame_err=0.
- Held-byte stream, BYTES_PER_WORD=2, MODE=0: 00, 4A, 24, 4B, 24, 4C, 24, 4D, 24, each byte held 4 cycles.
  - Required: word_count=2, frame_err=0.
  - Then MODE=2 with address 0 -> 0x4A4B; address 1 -> 0x4C4D; address 2 -> 0x0000.
- Debug stepping after the load above, MODE=1: data_out=0x4A4B; after 1 DEBUG pulse 0x4C4D; after 4 further pulses still 0x4C4D (saturation); DEBUG held 10 cycles = 1 step.
- Framing and partial word: stream 4A, 4B with no delimiter -> frame_err=1 and word 0x4A4B stored. Then byte 11 followed by MODE=1 -> partial word discarded, word_count unchanged.
- Overflow, DEPTH=4, BYTES_PER_WORD=1: load 5 delimited bytes 01..05 -> word_count=4, full=1, overflow=1, mem[3]=04.
- Clear and async reset: MODE=3 for 1 cycle -> word_count=0, full=0, overflow=0. Assert rst=0 mid-byte between clock edges -> outputs go to 0 immediately without waiting for a clk edge.
